// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers a branch-only program counter (increment / hold / redirect),
// handshakes with instruction memory and keeps a small return-address stack for call/ret.
module fetch_sequencer #(
    parameter int                ADDR_W       = 10,
    parameter int                RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 10'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          pc,
    input  logic                       imem_ready,
    input  logic                       stall,
    input  logic                       jump_req,
    input  logic [ADDR_W-1:0]          jump_target,
    input  logic                       call_req,
    input  logic [ADDR_W-1:0]          call_target,
    input  logic                       ret_req,
    input  logic                       halt_req,
    input  logic                       resume,
    output logic                       pc_branch,
    output logic [ADDR_W-1:0]          pc_branch_addr,
    output logic                       fetch_req,
    output logic [ADDR_W-1:0]          fetch_addr,
    output logic                       advance,
    output logic                       halted,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_err
);
    localparam int                PTR_W   = $clog2(RAS_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   ras_count_q, ras_count_d;
    logic               ras_err_q, ras_err_d;
    logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0]  ras_d [RAS_DEPTH];

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  ras_top;
    logic [PTR_W-1:0]   push_idx;
    logic [PTR_W-1:0]   top_idx;
    logic               accept;

    // A full stack has count == RAS_DEPTH, whose low bits wrap to 0, so the top is still index-1.
    assign pc_inc     = pc + ADDR_ONE;
    assign push_idx   = ras_count_q[PTR_W-1:0];
    assign top_idx    = push_idx - PTR_ONE;
    assign ras_top    = ras_q[top_idx];
    assign accept     = imem_ready & ~stall;
    assign fetch_addr = pc;
    assign ras_count  = ras_count_q;
    assign ras_err    = ras_err_q;

    // Next-state, RAS update and PC steering; holding the PC means branching to itself.
    always_comb begin
        state_d        = state_q;
        ras_count_d    = ras_count_q;
        ras_err_d      = ras_err_q;
        ras_d          = ras_q;
        pc_branch      = 1'b0;
        pc_branch_addr = pc;
        fetch_req      = 1'b0;
        advance        = 1'b0;
        halted         = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pc_branch      = 1'b1;
                pc_branch_addr = RESET_VECTOR;
                state_d        = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_req = 1'b1;
                advance   = accept;
                if (!accept) begin
                    pc_branch      = 1'b1;
                    pc_branch_addr = pc;
                end else if (halt_req) begin
                    pc_branch      = 1'b1;
                    pc_branch_addr = pc_inc;
                    state_d        = ST_HALT;
                end else if (ret_req) begin
                    if (ras_count_q != {CNT_W{1'b0}}) begin
                        pc_branch      = 1'b1;
                        pc_branch_addr = ras_top;
                        ras_count_d    = ras_count_q - CNT_ONE;
                    end else begin
                        ras_err_d = 1'b1;
                    end
                end else if (call_req) begin
                    pc_branch      = 1'b1;
                    pc_branch_addr = call_target;
                    if (ras_count_q < DEPTH_C) begin
                        ras_d[push_idx] = pc_inc;
                        ras_count_d     = ras_count_q + CNT_ONE;
                    end else begin
                        ras_err_d = 1'b1;
                    end
                end else if (jump_req) begin
                    pc_branch      = 1'b1;
                    pc_branch_addr = jump_target;
                end else begin
                    pc_branch = 1'b0;
                end
            end
            ST_HALT: begin
                halted         = 1'b1;
                pc_branch      = 1'b1;
                pc_branch_addr = pc;
                if (resume) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                pc_branch      = 1'b1;
                pc_branch_addr = RESET_VECTOR;
                state_d        = ST_BOOT;
            end
        endcase
    end

    // Control state, stack occupancy and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            ras_count_q <= {CNT_W{1'b0}};
            ras_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ras_count_q <= ras_count_d;
            ras_err_q   <= ras_err_d;
        end
    end

    // Stack storage; contents are meaningless while the occupancy says empty.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, then randomized traffic checked
// against a queue-based reference model. A simple PC register closes the loop.
module tb_fetch_sequencer;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam logic [4:0] RQ_N   = 5'b00000;
    localparam logic [4:0] RQ_RES = 5'b00001;
    localparam logic [4:0] RQ_J   = 5'b00010;
    localparam logic [4:0] RQ_C   = 5'b00100;
    localparam logic [4:0] RQ_R   = 5'b01000;
    localparam logic [4:0] RQ_H   = 5'b10000;
    localparam int M_BOOT = 0, M_FETCH = 1, M_HALT = 2;

    logic          clk = 1'b0;
    logic          reset, imem_ready, stall, jump_req, call_req, ret_req, halt_req, resume;
    logic [AW-1:0] pc, jump_target, call_target;
    logic          pc_branch, fetch_req, advance, halted, ras_err;
    logic [AW-1:0] pc_branch_addr, fetch_addr;
    logic [2:0]    ras_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int rst, rdy, stl;
        logic [4:0] req;
        int jt, ct;
        int e_pc, e_adv, e_br, e_ba, e_hlt, e_cnt, e_err;
    } vec_t;
    vec_t tbl[$];

    int m_mode, m_pc, m_err, m_pc_known;
    int m_q[$];

    fetch_sequencer #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_VECTOR(10'd0)) dut (
        .clk(clk), .reset(reset), .pc(pc), .imem_ready(imem_ready), .stall(stall),
        .jump_req(jump_req), .jump_target(jump_target), .call_req(call_req),
        .call_target(call_target), .ret_req(ret_req), .halt_req(halt_req), .resume(resume),
        .pc_branch(pc_branch), .pc_branch_addr(pc_branch_addr), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .advance(advance), .halted(halted),
        .ras_count(ras_count), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    // The program counter block: load on branch, otherwise increment (wraps naturally).
    always @(posedge clk) pc <= pc_branch ? pc_branch_addr : pc + 10'd1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int rst, input int rdy, input int stl, input logic [4:0] req,
                         input int jt, input int ct);
        reset       = (rst != 0);
        imem_ready  = (rdy != 0);
        stall       = (stl != 0);
        halt_req    = req[4];
        ret_req     = req[3];
        call_req    = req[2];
        jump_req    = req[1];
        resume      = req[0];
        jump_target = AW'(jt);
        call_target = AW'(ct);
    endtask

    function automatic vec_t v(input int rst, input int rdy, input int stl, input logic [4:0] req,
                               input int jt, input int ct, input int e_pc, input int e_adv,
                               input int e_br, input int e_ba, input int e_hlt, input int e_cnt,
                               input int e_err);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.stl = stl; r.req = req; r.jt = jt; r.ct = ct;
        r.e_pc = e_pc; r.e_adv = e_adv; r.e_br = e_br; r.e_ba = e_ba;
        r.e_hlt = e_hlt; r.e_cnt = e_cnt; r.e_err = e_err;
        return r;
    endfunction

    // Reference model: one cycle of expected behaviour from the current inputs, then advance.
    task automatic model_step();
        int inc, e_ba, e_br, e_adv, e_fr, e_hlt, nxt_mode, nxt_err;
        inc = (m_pc + 1) % 1024;
        e_br = 0; e_ba = m_pc; e_adv = 0; e_fr = 0; e_hlt = 0;
        nxt_mode = m_mode; nxt_err = m_err;
        if (m_pc_known != 0) check("rnd.pc", int'(pc), m_pc);
        check("rnd.ras_count", int'(ras_count), m_q.size());
        check("rnd.ras_err", int'(ras_err), m_err);
        if (m_mode == M_BOOT) begin
            e_br = 1; e_ba = 0; nxt_mode = M_FETCH;
        end else if (m_mode == M_HALT) begin
            e_hlt = 1; e_br = 1; e_ba = m_pc;
            if (resume) nxt_mode = M_FETCH;
        end else begin
            e_fr = 1;
            e_adv = (imem_ready && !stall) ? 1 : 0;
            if (e_adv == 0) begin
                e_br = 1; e_ba = m_pc;
            end else if (halt_req) begin
                e_br = 1; e_ba = inc; nxt_mode = M_HALT;
            end else if (ret_req) begin
                if (m_q.size() > 0) begin
                    e_br = 1; e_ba = m_q[$];
                    if (!reset) void'(m_q.pop_back());
                end else nxt_err = 1;
            end else if (call_req) begin
                e_br = 1; e_ba = int'(call_target);
                if (m_q.size() < DEPTH) begin
                    if (!reset) m_q.push_back(inc);
                end else nxt_err = 1;
            end else if (jump_req) begin
                e_br = 1; e_ba = int'(jump_target);
            end
        end
        check("rnd.advance", int'(advance), e_adv);
        check("rnd.fetch_req", int'(fetch_req), e_fr);
        check("rnd.halted", int'(halted), e_hlt);
        check("rnd.pc_branch", int'(pc_branch), e_br);
        if (e_br != 0 && (m_pc_known != 0 || m_mode == M_BOOT))
            check("rnd.pc_branch_addr", int'(pc_branch_addr), e_ba);
        if (e_fr != 0 && m_pc_known != 0) check("rnd.fetch_addr", int'(fetch_addr), m_pc);
        if (m_pc_known != 0 || m_mode == M_BOOT) begin
            m_pc = (e_br != 0) ? e_ba : inc;
            m_pc_known = 1;
        end
        if (reset) begin
            m_mode = M_BOOT; m_err = 0; m_q.delete();
        end else begin
            m_mode = nxt_mode; m_err = nxt_err;
        end
    endtask

    initial begin
        drive(1, 0, 0, RQ_N, 0, 0);
        //          rst rdy stl req          jt    ct    pc   adv br ba   hlt cnt err
        tbl.push_back(v(1, 1, 0, RQ_N,        0,    0,   -2,  0, 0, 0,    0, 0, 0));
        tbl.push_back(v(1, 1, 0, RQ_N,        0,    0,   -2,  0, 0, 0,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,   -1,  0, 1, 0,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,    0,  1, 0, 0,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,    1,  1, 0, 0,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,    2,  1, 0, 0,    0, 0, 0));
        tbl.push_back(v(0, 1, 1, RQ_J,      500,    0,    3,  0, 1, 3,    0, 0, 0));
        tbl.push_back(v(0, 1, 1, RQ_N,        0,    0,    3,  0, 1, 3,    0, 0, 0));
        tbl.push_back(v(0, 1, 1, RQ_N,        0,    0,    3,  0, 1, 3,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,    3,  1, 0, 0,    0, 0, 0));
        tbl.push_back(v(0, 0, 0, RQ_C,        0,  600,    4,  0, 1, 4,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,    4,  1, 0, 0,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_C,        0,  100,    5,  1, 1, 100,  0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,  100,  1, 0, 0,    0, 1, 0));
        tbl.push_back(v(0, 1, 0, RQ_R,        0,    0,  101,  1, 1, 6,    0, 1, 0));
        tbl.push_back(v(0, 1, 0, RQ_C,        0,   10,    6,  1, 1, 10,   0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_C,        0,   20,   10,  1, 1, 20,   0, 1, 0));
        tbl.push_back(v(0, 1, 0, RQ_C,        0,   30,   20,  1, 1, 30,   0, 2, 0));
        tbl.push_back(v(0, 1, 0, RQ_C,        0,   40,   30,  1, 1, 40,   0, 3, 0));
        tbl.push_back(v(0, 1, 0, RQ_C,        0,   50,   40,  1, 1, 50,   0, 4, 0));
        tbl.push_back(v(0, 1, 0, RQ_R,        0,    0,   50,  1, 1, 31,   0, 4, 1));
        tbl.push_back(v(0, 1, 0, RQ_R,        0,    0,   31,  1, 1, 21,   0, 3, 1));
        tbl.push_back(v(0, 1, 0, RQ_R,        0,    0,   21,  1, 1, 11,   0, 2, 1));
        tbl.push_back(v(0, 1, 0, RQ_R,        0,    0,   11,  1, 1, 7,    0, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_J | RQ_C, 200,  300,   7,  1, 1, 300,  0, 0, 1));
        tbl.push_back(v(0, 1, 0, RQ_H | RQ_J, 999,    0, 300,  1, 1, 301,  0, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_C,        0,   77,  301,  0, 1, 301,  1, 1, 1));
        tbl.push_back(v(0, 0, 1, RQ_J,      400,    0,  301,  0, 1, 301,  1, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_R,        0,    0,  301,  0, 1, 301,  1, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_H,        0,    0,  301,  0, 1, 301,  1, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_RES,      0,    0,  301,  0, 1, 301,  1, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,  301,  1, 0, 0,    0, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_J,     1023,    0,  302,  1, 1, 1023, 0, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0, 1023,  1, 0, 0,    0, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_J,     1023,    0,    0,  1, 1, 1023, 0, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_C,        0,    5, 1023,  1, 1, 5,    0, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_R,        0,    0,    5,  1, 1, 0,    0, 2, 1));
        tbl.push_back(v(0, 1, 0, RQ_H,        0,    0,    0,  1, 1, 1,    0, 1, 1));
        tbl.push_back(v(1, 1, 0, RQ_N,        0,    0,    1,  0, 1, 1,    1, 1, 1));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,    1,  0, 1, 0,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_R,        0,    0,    0,  1, 0, 0,    0, 0, 0));
        tbl.push_back(v(0, 1, 0, RQ_N,        0,    0,    1,  1, 0, 0,    0, 0, 1));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].stl, tbl[i].req, tbl[i].jt, tbl[i].ct);
            @(negedge clk);
            if (tbl[i].e_pc != -2) begin
                if (tbl[i].e_pc >= 0) check($sformatf("row%0d.pc", i), int'(pc), tbl[i].e_pc);
                check($sformatf("row%0d.advance", i), int'(advance), tbl[i].e_adv);
                check($sformatf("row%0d.pc_branch", i), int'(pc_branch), tbl[i].e_br);
                if (tbl[i].e_br != 0)
                    check($sformatf("row%0d.pc_branch_addr", i), int'(pc_branch_addr), tbl[i].e_ba);
                check($sformatf("row%0d.halted", i), int'(halted), tbl[i].e_hlt);
                check($sformatf("row%0d.ras_count", i), int'(ras_count), tbl[i].e_cnt);
                check($sformatf("row%0d.ras_err", i), int'(ras_err), tbl[i].e_err);
            end
            @(posedge clk); #1;
        end

        // Randomized phase: start from a fresh reset so the model knows the state.
        drive(1, 1, 0, RQ_N, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_mode = M_BOOT; m_err = 0; m_pc = 0; m_pc_known = 0; m_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] rq;
            rq[4] = ($urandom_range(0, 9) == 0);
            rq[3] = ($urandom_range(0, 3) == 0);
            rq[2] = ($urandom_range(0, 3) == 0);
            rq[1] = ($urandom_range(0, 4) == 0);
            rq[0] = ($urandom_range(0, 3) == 0);
            drive(($urandom_range(0, 79) == 0) ? 1 : 0,
                  ($urandom_range(0, 4) != 0) ? 1 : 0,
                  ($urandom_range(0, 4) == 0) ? 1 : 0,
                  rq, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            @(negedge clk);
            model_step();
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
